// File: rtl/iexecute_pkg.sv
// exec_defs: ALU control codes and execute-stage FSM states.
// Defines the global WORD datapath width.
`ifndef WORD
`define WORD 64
`endif

package exec_defs;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_MUL  = 4'b1000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;
endpackage

// File: rtl/iexecute_if.sv
// iexecute_if: decode->execute handshake and execute->memory bundle.
// master = decode/memory side, slave = execute stage.
interface iexecute_if;
  logic              in_valid;
  logic              in_ready;
  logic [`WORD-1:0]  pc;
  logic [`WORD-1:0]  read_data1;
  logic [`WORD-1:0]  read_data2;
  logic [`WORD-1:0]  sign_extend;
  logic              alu_src;
  logic [3:0]        alu_control;
  logic              out_valid;
  logic [`WORD-1:0]  alu_result;
  logic              zero;
  logic [`WORD-1:0]  branch_target;
  logic [`WORD-1:0]  mem_write_data;

  modport master (
    output in_valid, pc, read_data1, read_data2,
    output sign_extend, alu_src, alu_control,
    input  in_ready, out_valid, alu_result, zero,
    input  branch_target, mem_write_data
  );

  modport slave (
    input  in_valid, pc, read_data1, read_data2,
    input  sign_extend, alu_src, alu_control,
    output in_ready, out_valid, alu_result, zero,
    output branch_target, mem_write_data
  );
endinterface

// File: rtl/iexecute_mul.sv
// mul_iter: WORD-cycle shift-add multiplier, low WORD bits of a*b.
// Ports: clk, rst_n, i_start, i_a, i_b -> o_done, o_product.
module mul_iter (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [`WORD-1:0] i_a,
  input  logic [`WORD-1:0] i_b,
  output logic             o_done,
  output logic [`WORD-1:0] o_product
);
  localparam int CW = $clog2(`WORD);
  localparam logic [CW-1:0] LAST = CW'(`WORD - 1);

  logic [`WORD-1:0] r_mcand;
  logic [`WORD-1:0] r_mplier;
  logic [`WORD-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic [`WORD-1:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? r_acc + r_mcand : r_acc;
  // product is the accumulator after the final iteration
  assign o_done     = r_busy && (r_count == LAST);
  assign o_product  = w_acc_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_count  <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
      if (r_count == LAST)
        r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/iexecute.sv
// iexecute: LEGv8 execute stage; ALU, zero flag, branch target.
// Ports: clk, rst_n, ex (iexecute_if.slave handshake + results).
module iexecute
  import exec_defs::*;
(
  input logic       clk,
  input logic       rst_n,
  iexecute_if.slave ex
);
  state_t           r_state;
  logic             r_out_valid;
  logic [`WORD-1:0] r_alu_result;
  logic             r_zero;
  logic [`WORD-1:0] r_branch_target;
  logic [`WORD-1:0] r_mem_write_data;

  logic [`WORD-1:0] w_opb;
  logic [`WORD-1:0] w_alu;
  logic [`WORD-1:0] w_product;
  logic             w_accept;
  logic             w_start;
  logic             w_done;

  assign w_opb    = ex.alu_src ? ex.sign_extend : ex.read_data2;
  assign w_accept = ex.in_valid && (r_state == S_IDLE);
  assign w_start  = w_accept && (ex.alu_control == ALU_MUL);

  assign ex.in_ready       = (r_state == S_IDLE);
  assign ex.out_valid      = r_out_valid;
  assign ex.alu_result     = r_alu_result;
  assign ex.zero           = r_zero;
  assign ex.branch_target  = r_branch_target;
  assign ex.mem_write_data = r_mem_write_data;

  always_comb begin
    w_alu = '0;
    unique case (1'b1)
      (ex.alu_control == ALU_AND):  w_alu = ex.read_data1 & w_opb;
      (ex.alu_control == ALU_ORR):  w_alu = ex.read_data1 | w_opb;
      (ex.alu_control == ALU_ADD):  w_alu = ex.read_data1 + w_opb;
      (ex.alu_control == ALU_SUB):  w_alu = ex.read_data1 - w_opb;
      (ex.alu_control == ALU_PASS): w_alu = w_opb;
      (ex.alu_control == ALU_NOR):  w_alu = ~(ex.read_data1 | w_opb);
      default:                      w_alu = '0;
    endcase
  end

  mul_iter u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_a       (ex.read_data1),
    .i_b       (w_opb),
    .o_done    (w_done),
    .o_product (w_product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_out_valid      <= 1'b0;
      r_alu_result     <= '0;
      r_zero           <= 1'b0;
      r_branch_target  <= '0;
      r_mem_write_data <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_branch_target  <= ex.pc + (ex.sign_extend << 2);
            r_mem_write_data <= ex.read_data2;
            if (w_start) begin
              r_state <= S_MUL;
            end else begin
              r_alu_result <= w_alu;
              r_zero       <= (w_alu == '0);
              r_out_valid  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (w_done) begin
            r_alu_result <= w_product;
            r_zero       <= (w_product == '0);
            r_out_valid  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/iexecute.md
# iexecute

Execute stage of the LEGv8 datapath, sitting directly upstream of the memory stage. Accepts decoded operands from decode, computes the ALU result, zero flag and branch target, and passes the store data through. Single-cycle ALU operations complete in one cycle. MUL runs on an iterative shift-add multiplier over 64 cycles, and the stage stalls decode through a valid/ready handshake while it does.

## Interface

**Parameters**

- `WORD`, 64 (shared `` `WORD `` define): datapath width.

**Ports**

- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `in_valid`  in  1: decode presents an instruction.
- `in_ready`  out  1: stage can accept; equals 1 when state is IDLE.
- `pc`  in  WORD: PC of the presented instruction.
- `read_data1`  in  WORD: operand A.
- `read_data2`  in  WORD: register operand B; also the store data.
- `sign_extend`  in  WORD: sign-extended immediate/offset.
- `alu_src`  in  1: 1 selects `sign_extend` as operand B, 0 selects `read_data2`.
- `alu_control`  in  4: operation select.
- `out_valid`  out  1: one-cycle pulse when the registered results are new.
- `alu_result`  out  WORD: registered result, feeds `mem_address`.
- `zero`  out  1: registered, equals (`alu_result` == 0).
- `branch_target`  out  WORD: registered, `pc + (sign_extend << 2)`, modulo 2^WORD.
- `mem_write_data`  out  WORD: registered copy of `read_data2`.

## Operation

**ALU operations** (`alu_control` encoding)

- 0000: AND
- 0001: ORR
- 0010: ADD
- 0110: SUB (A − B)
- 0111: pass B (CBZ)
- 1100: NOR
- 1000: MUL, low WORD bits of A×B
- Any other code: result 0, zero 1.

**Arithmetic**

- All arithmetic is modulo 2^WORD. No flags other than `zero`.

**Accept**

- An instruction is accepted on a rising edge where `in_valid & in_ready & rst_n`.
- `branch_target` and `mem_write_data` are captured at the accept edge for every operation.

**State machine** (states IDLE, MUL)

- **IDLE, non-MUL accept:** register `alu_result` and `zero`, pulse `out_valid`, stay in IDLE.
- **IDLE, MUL accept:**
  - Load multiplicand = A, multiplier = B, acc = 0, count = 0.
  - Go to MUL; `in_ready` drops to 0.
- **MUL, each edge:**
  - If multiplier[0] = 1, acc += multiplicand.
  - Shift multiplicand left 1 and multiplier right 1; count++.
  - On the edge where count == WORD−1: write the final acc to `alu_result`, update `zero`, pulse `out_valid`, return to IDLE.
  - There is no early termination.
- **IDLE, no accept:** outputs hold their values; `out_valid` = 0.

**Boundary conditions**

- Back-to-back accepts in IDLE give back-to-back `out_valid` pulses.
- An accept in the cycle `out_valid` is high is legal.
- `in_valid` while in MUL is ignored; decode must hold its inputs until accepted.
- Reset mid-MUL aborts the multiply: no `out_valid`, partial product discarded.
- There is no downstream backpressure; the memory stage always consumes `out_valid`.

## Timing

**Reset value of every output**

- Applied at the edge where `rst_n` = 0.
- `alu_result`, `branch_target`, `mem_write_data`: 0.
- `zero`: 0.
- `out_valid`: 0.
- State IDLE, so `in_ready` = 1 after reset.
- While `rst_n` = 0, no accept occurs.

**Latency**

- Non-MUL: accept at edge N, results and `out_valid` visible after edge N (1 cycle).
- MUL: accept at edge N, iterations at edges N+1..N+WORD, result and `out_valid` visible after edge N+WORD. `in_ready` is 0 after edges N..N+WORD−1.
- Throughput: 1 instruction/cycle for non-MUL, 1 per WORD+1 cycles for MUL.

## Structure

- Shared package `exec_defs` holds the `alu_control` encoding constants and the state encoding. `` `WORD `` stays a global define.
- One sub-module, `mul_iter`, holds the multiplicand/multiplier/acc/count registers.
  - Inputs: start, a, b.
  - Outputs: done, product.
  - It is synchronously cleared by `rst_n`.
- `iexecute` holds the FSM, the combinational ALU and the output registers.

## Test plan

1. Reset, then ADD with A=5, B=7, `alu_src`=0 → `alu_result`=12, `zero`=0, `out_valid` for 1 cycle; `in_ready` stays 1.
2. SUB with A=B=0x10 → `alu_result`=0, `zero`=1. CBZ pass-B with `read_data2`=0 → `zero`=1. `pc`=0x100, `sign_extend`=−2 → `branch_target`=0xF8.
3. MUL with A=0xFFFF_FFFF_FFFF_FFFF, B=3 → `in_ready`=0 for exactly 64 cycles, then `alu_result`=0xFFFF_FFFF_FFFF_FFFD and one `out_valid` pulse 64 cycles after accept. A second `in_valid` held during the multiply is accepted on the cycle `in_ready` returns.
4. Back-to-back AND, ORR, NOR on A=0xF0, B=0x3C → 0x30, 0xFC, 0xFFFF_FFFF_FFFF_FF03 on consecutive cycles, with `out_valid` high on three consecutive cycles.
5. `rst_n` low at iteration 30 of a MUL → no `out_valid`, all outputs 0, `in_ready`=1. The next ADD 1+1 → 2.
6. `alu_src`=1, A=0x1000, `sign_extend`=0x20, ADD → `alu_result`=0x1020 and `mem_write_data` equal to `read_data2`. An unknown `alu_control` of 1111 → result 0, `zero`=1.
